// File: rtl/keypad_scanner_if.sv
// Keypad matrix interface: column drive, row sense and the decoded key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

    logic [ROWS-1:0]   row;
    logic [COLS-1:0]   col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_release;
    logic              key_held;
    logic              multi_key;

    modport master (
        input  row,
        output col, key_code, key_valid, key_release, key_held, multi_key
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, key_release, key_held, multi_key
    );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: rotates a one-cold column drive, debounces the row
// pattern on prescaler ticks and reports press/release of the frozen key.
//
// state           | meaning
// ST_SCAN         | rotating columns, waiting for any low row
// ST_DEBOUNCE     | column frozen, counting matching press ticks
// ST_HELD         | key confirmed, waiting for all rows high
// ST_REL_DEBOUNCE | counting all-high ticks to confirm release
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 8
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);
    localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW     = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_REL_DEBOUNCE
    } state_t;

    state_t            state, state_nxt;
    logic [ROWS-1:0]   row_m, row_s;
    logic [PW-1:0]     pre;
    logic              tick;
    logic [CW-1:0]     col_idx, col_idx_nxt, col_next;
    logic [7:0]        cnt, cnt_nxt, cnt_inc;
    logic [ROWS-1:0]   cap, cap_nxt;
    logic [CODE_W-1:0] code, code_nxt;
    logic              held, held_nxt;
    logic              multi, multi_nxt;
    logic              valid, valid_nxt;
    logic              rel, rel_nxt;
    logic              press_ok, release_ok;
    logic              row_all_high;
    logic [RW-1:0]     low_row;
    logic [3:0]        low_count;
    logic [31:0]       code_full;

    // row is asynchronous to clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= kp.row;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    assign tick         = (pre == PW'(SCAN_DIV - 1));
    assign row_all_high = &row_s;
    assign col_next     = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);
    assign cnt_inc      = cnt + 8'd1;

    always_comb begin
        low_row   = '0;
        low_count = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row_s[i]) begin
                low_row   = RW'(i);
                low_count = low_count + 4'd1;
            end
        end
    end

    assign code_full = 32'(low_row) * 32'(COLS) + 32'(col_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_SCAN;
            col_idx <= '0;
            cnt     <= '0;
            cap     <= '1;
            code    <= '0;
            held    <= 1'b0;
            multi   <= 1'b0;
            valid   <= 1'b0;
            rel     <= 1'b0;
        end else begin
            state   <= state_nxt;
            col_idx <= col_idx_nxt;
            cnt     <= cnt_nxt;
            cap     <= cap_nxt;
            code    <= code_nxt;
            held    <= held_nxt;
            multi   <= multi_nxt;
            valid   <= valid_nxt;
            rel     <= rel_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        col_idx_nxt = col_idx;
        cnt_nxt     = cnt;
        cap_nxt     = cap;
        code_nxt    = code;
        held_nxt    = held;
        multi_nxt   = multi;
        valid_nxt   = 1'b0;
        rel_nxt     = 1'b0;
        press_ok    = 1'b0;
        release_ok  = 1'b0;

        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (row_all_high) begin
                        col_idx_nxt = col_next;
                    end else begin
                        cap_nxt   = row_s;
                        cnt_nxt   = 8'd1;
                        state_nxt = ST_DEBOUNCE;
                        press_ok  = (DEBOUNCE == 1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s == cap) begin
                        cnt_nxt  = cnt_inc;
                        press_ok = (cnt_inc == 8'(DEBOUNCE));
                    end else begin
                        state_nxt   = ST_SCAN;
                        col_idx_nxt = col_next;
                    end
                end
                ST_HELD: begin
                    if (row_all_high) begin
                        cnt_nxt    = 8'd1;
                        state_nxt  = ST_REL_DEBOUNCE;
                        release_ok = (DEBOUNCE == 1);
                    end
                end
                ST_REL_DEBOUNCE: begin
                    if (row_all_high) begin
                        cnt_nxt    = cnt_inc;
                        release_ok = (cnt_inc == 8'(DEBOUNCE));
                    end else begin
                        state_nxt = ST_HELD;
                    end
                end
                default: state_nxt = ST_SCAN;
            endcase
        end

        // on confirmation row_s equals the captured pattern
        if (press_ok) begin
            state_nxt = ST_HELD;
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            code_nxt  = code_full[CODE_W-1:0];
            multi_nxt = (low_count > 4'd1);
        end
        if (release_ok) begin
            state_nxt   = ST_SCAN;
            rel_nxt     = 1'b1;
            held_nxt    = 1'b0;
            multi_nxt   = 1'b0;
            col_idx_nxt = col_next;
        end
    end

    assign kp.col         = ~({{(COLS - 1){1'b0}}, 1'b1} << col_idx);
    assign kp.key_code    = code;
    assign kp.key_valid   = valid;
    assign kp.key_release = rel;
    assign kp.key_held    = held;
    assign kp.multi_key   = multi;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3.
// Each table row is one scan-tick period of row stimulus plus the expected outcome.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    keypad_scanner_if #(.ROWS(4), .COLS(4)) kp ();

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp(kp)
    );

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        int         nvalid;
        int         nrel;
        logic       held;
        logic [3:0] code;
        logic       multi;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vec [NVEC];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Applies one vector for a full 4-clock tick period, counting pulses at negedges.
    task automatic run_vec(input int i, input string tag);
        int nv = 0;
        int nr = 0;
        int both = 0;
        kp.row = vec[i].row;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (kp.key_valid) nv++;
            if (kp.key_release) nr++;
            if (kp.key_valid && kp.key_release) both++;
        end
        check($sformatf("%s v%0d col", tag, i), 32'(kp.col), 32'(vec[i].col));
        check($sformatf("%s v%0d key_valid pulses", tag, i), nv, vec[i].nvalid);
        check($sformatf("%s v%0d key_release pulses", tag, i), nr, vec[i].nrel);
        check($sformatf("%s v%0d key_held", tag, i), 32'(kp.key_held), 32'(vec[i].held));
        check($sformatf("%s v%0d key_code", tag, i), 32'(kp.key_code), 32'(vec[i].code));
        check($sformatf("%s v%0d multi_key", tag, i), 32'(kp.multi_key), 32'(vec[i].multi));
        check($sformatf("%s v%0d valid&release overlap", tag, i), both, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check($sformatf("%s col", tag), 32'(kp.col), 32'h0e);
        check($sformatf("%s key_code", tag), 32'(kp.key_code), 0);
        check($sformatf("%s key_valid", tag), 32'(kp.key_valid), 0);
        check($sformatf("%s key_release", tag), 32'(kp.key_release), 0);
        check($sformatf("%s key_held", tag), 32'(kp.key_held), 0);
        check($sformatf("%s multi_key", tag), 32'(kp.multi_key), 0);
    endtask

    initial begin
        int nr;
        //          row      col      v  r  held  code  multi
        vec[0]  = '{4'b1111, 4'b1101, 0, 0, 1'b0, 4'd0, 1'b0};  // idle rotation
        vec[1]  = '{4'b1111, 4'b1011, 0, 0, 1'b0, 4'd0, 1'b0};
        vec[2]  = '{4'b1111, 4'b0111, 0, 0, 1'b0, 4'd0, 1'b0};
        vec[3]  = '{4'b1111, 4'b1110, 0, 0, 1'b0, 4'd0, 1'b0};
        vec[4]  = '{4'b1111, 4'b1101, 0, 0, 1'b0, 4'd0, 1'b0};
        vec[5]  = '{4'b1011, 4'b1101, 0, 0, 1'b0, 4'd0, 1'b0};  // clean press row2/col1
        vec[6]  = '{4'b1011, 4'b1101, 0, 0, 1'b0, 4'd0, 1'b0};
        vec[7]  = '{4'b1011, 4'b1101, 1, 0, 1'b1, 4'd9, 1'b0};
        vec[8]  = '{4'b1011, 4'b1101, 0, 0, 1'b1, 4'd9, 1'b0};
        vec[9]  = '{4'b1111, 4'b1101, 0, 0, 1'b1, 4'd9, 1'b0};  // release glitch
        vec[10] = '{4'b1011, 4'b1101, 0, 0, 1'b1, 4'd9, 1'b0};
        vec[11] = '{4'b1111, 4'b1101, 0, 0, 1'b1, 4'd9, 1'b0};  // clean release
        vec[12] = '{4'b1111, 4'b1101, 0, 0, 1'b1, 4'd9, 1'b0};
        vec[13] = '{4'b1111, 4'b1011, 0, 1, 1'b0, 4'd9, 1'b0};
        vec[14] = '{4'b0110, 4'b1011, 0, 0, 1'b0, 4'd9, 1'b0};  // multi-key rows 0,3
        vec[15] = '{4'b0110, 4'b1011, 0, 0, 1'b0, 4'd9, 1'b0};
        vec[16] = '{4'b0110, 4'b1011, 1, 0, 1'b1, 4'd2, 1'b1};
        vec[17] = '{4'b1111, 4'b1011, 0, 0, 1'b1, 4'd2, 1'b1};
        vec[18] = '{4'b1111, 4'b1011, 0, 0, 1'b1, 4'd2, 1'b1};
        vec[19] = '{4'b1111, 4'b0111, 0, 1, 1'b0, 4'd2, 1'b0};
        vec[20] = '{4'b1111, 4'b1110, 0, 0, 1'b0, 4'd2, 1'b0};
        vec[21] = '{4'b1111, 4'b1101, 0, 0, 1'b0, 4'd2, 1'b0};
        vec[22] = '{4'b1011, 4'b1101, 0, 0, 1'b0, 4'd2, 1'b0};  // bounce
        vec[23] = '{4'b1011, 4'b1101, 0, 0, 1'b0, 4'd2, 1'b0};
        vec[24] = '{4'b1111, 4'b1011, 0, 0, 1'b0, 4'd2, 1'b0};
        vec[25] = '{4'b1101, 4'b1011, 0, 0, 1'b0, 4'd2, 1'b0};  // press row1/col2
        vec[26] = '{4'b1101, 4'b1011, 0, 0, 1'b0, 4'd2, 1'b0};
        vec[27] = '{4'b1101, 4'b1011, 1, 0, 1'b1, 4'd6, 1'b0};

        rst    = 1'b0;
        kp.row = 4'b1111;
        repeat (3) @(negedge clk);
        check_reset_values("power-on reset");
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, "seq");
        end

        // Reset while HELD: outputs clear at once and no release pulse escapes.
        check("pre-reset key_held", 32'(kp.key_held), 1);
        rst    = 1'b0;
        kp.row = 4'b1111;
        #1;
        check_reset_values("reset while held");
        nr = 0;
        repeat (3) begin
            @(negedge clk);
            if (kp.key_release) nr++;
        end
        check("release pulses during reset", nr, 0);
        rst = 1'b1;
        #1;
        check("col after reset release", 32'(kp.col), 32'h0e);
        #4;
        run_vec(0, "post-reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
